// File: rtl/pe_feed_if.sv
// rtl/pe_feed_if.sv - SRAM read, PE buffer push and PE handshake bundle for pe_feed_scheduler
interface pe_feed_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                    filt_rd_en;
    logic [ADDR_WIDTH-1:0]   filt_rd_addr;
    logic [DATA_WIDTH-1:0]   filt_rd_data;
    logic                    ifm_rd_en;
    logic [ADDR_WIDTH-1:0]   ifm_rd_addr;
    logic [DATA_WIDTH-1:0]   ifm_rd_data;
    logic                    filt_wr_en;
    logic [DATA_WIDTH-1:0]   filt_wr_data;
    logic                    filt_full;
    logic                    ifm_wr_en;
    logic [DATA_WIDTH+1:0]   ifm_wr_data;
    logic                    ifm_full;
    logic                    pe_start;
    logic                    pe_done;

    modport master (
        output filt_rd_en, filt_rd_addr, input filt_rd_data,
        output ifm_rd_en, ifm_rd_addr, input ifm_rd_data,
        output filt_wr_en, filt_wr_data, input filt_full,
        output ifm_wr_en, ifm_wr_data, input ifm_full,
        output pe_start, input pe_done
    );

    modport slave (
        input filt_rd_en, filt_rd_addr, output filt_rd_data,
        input ifm_rd_en, ifm_rd_addr, output ifm_rd_data,
        input filt_wr_en, filt_wr_data, output filt_full,
        input ifm_wr_en, ifm_wr_data, output ifm_full,
        input pe_start, output pe_done
    );
endinterface

// File: rtl/pe_feed_scheduler.sv
// rtl/pe_feed_scheduler.sv - Eyeriss PE feed sequencer: filter/ifmap fetch, row tagging, PE start/done
// Optional STALL_CNT_EN adds the stall_cycles output counting full-blocked load cycles.
module pe_feed_scheduler #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int FSIZE_WIDTH = 4,
    parameter int ROWS_WIDTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [FSIZE_WIDTH-1:0] filter_size,
    input  logic [ADDR_WIDTH-1:0]  ifmap_len,
    input  logic [ROWS_WIDTH-1:0]  num_rows,
    pe_feed_if.master              bus,
    output logic                   busy,
    output logic                   done
`ifdef STALL_CNT_EN
    ,
    output logic [15:0]            stall_cycles
`endif
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PSTART = 3'd1;
    localparam logic [2:0] S_LDFILT = 3'd2;
    localparam logic [2:0] S_LDROW  = 3'd3;
    localparam logic [2:0] S_WAITPE = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]             state_q;
    logic [FSIZE_WIDTH-1:0] fsize_q;
    logic [ADDR_WIDTH-1:0]  ilen_q;
    logic [ROWS_WIDTH-1:0]  rows_q;
    logic [ROWS_WIDTH-1:0]  row_q;
    logic [ADDR_WIDTH-1:0]  base_q;
    logic [ADDR_WIDTH-1:0]  issued_q;
    logic [ADDR_WIDTH-1:0]  written_q;
    logic                   pend_q;
    logic                   skid_vld_q;
    logic [DATA_WIDTH-1:0]  skid_q;
    logic                   done_q;

    logic                   ld_filt;
    logic                   ld_row;
    logic                   loading;
    logic                   cur_full;
    logic [ADDR_WIDTH-1:0]  cur_len;
    logic                   issue;
    logic                   wr;
    logic                   last_wr;
    logic                   zero_cfg;
    logic [DATA_WIDTH-1:0]  rd_word;
    logic [DATA_WIDTH-1:0]  wr_word;

    assign ld_filt  = (state_q == S_LDFILT);
    assign ld_row   = (state_q == S_LDROW);
    assign loading  = ld_filt | ld_row;
    assign cur_full = ld_filt ? bus.filt_full : bus.ifm_full;
    assign cur_len  = ld_filt ? ADDR_WIDTH'(fsize_q) : ilen_q;
    assign zero_cfg = (filter_size == '0) || (ifmap_len == '0) || (num_rows == '0);

    // Only one load path is active at a time, so a single read pipeline and skid slot serve both.
    assign issue   = loading && !cur_full && !skid_vld_q && (issued_q != cur_len);
    assign rd_word = ld_filt ? bus.filt_rd_data : bus.ifm_rd_data;
    assign wr      = loading && !cur_full && (skid_vld_q || pend_q);
    assign wr_word = skid_vld_q ? skid_q : rd_word;
    assign last_wr = wr && (written_q == cur_len - ADDR_WIDTH'(1));

    assign bus.filt_rd_en   = issue && ld_filt;
    assign bus.filt_rd_addr = (issue && ld_filt) ? issued_q : '0;
    assign bus.ifm_rd_en    = issue && ld_row;
    assign bus.ifm_rd_addr  = (issue && ld_row) ? (base_q + issued_q) : '0;
    assign bus.filt_wr_en   = wr && ld_filt;
    assign bus.filt_wr_data = (wr && ld_filt) ? wr_word : '0;
    assign bus.ifm_wr_en    = wr && ld_row;
    assign bus.ifm_wr_data  = (wr && ld_row) ? {(written_q == '0), last_wr, wr_word} : '0;
    assign bus.pe_start     = (state_q == S_PSTART);
    assign busy             = (state_q != S_IDLE);
    assign done             = done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            fsize_q    <= '0;
            ilen_q     <= '0;
            rows_q     <= '0;
            row_q      <= '0;
            base_q     <= '0;
            issued_q   <= '0;
            written_q  <= '0;
            pend_q     <= 1'b0;
            skid_vld_q <= 1'b0;
            skid_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= (state_q == S_DONE);
            pend_q <= issue;
            if (issue) issued_q <= issued_q + ADDR_WIDTH'(1);
            if (wr) written_q <= written_q + ADDR_WIDTH'(1);
            // Data returning into a full buffer parks here; no new read is issued until it drains.
            if (loading && cur_full && pend_q) begin
                skid_vld_q <= 1'b1;
                skid_q     <= rd_word;
            end else if (wr) begin
                skid_vld_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        fsize_q <= filter_size;
                        ilen_q  <= ifmap_len;
                        rows_q  <= num_rows;
                        row_q   <= '0;
                        base_q  <= '0;
                        state_q <= zero_cfg ? S_DONE : S_PSTART;
                    end
                end
                S_PSTART: begin
                    issued_q  <= '0;
                    written_q <= '0;
                    state_q   <= S_LDFILT;
                end
                S_LDFILT: begin
                    if (last_wr) begin
                        issued_q  <= '0;
                        written_q <= '0;
                        state_q   <= S_LDROW;
                    end
                end
                S_LDROW: begin
                    if (last_wr) state_q <= S_WAITPE;
                end
                S_WAITPE: begin
                    if (bus.pe_done) begin
                        if (row_q == rows_q - ROWS_WIDTH'(1)) begin
                            state_q <= S_DONE;
                        end else begin
                            row_q   <= row_q + ROWS_WIDTH'(1);
                            base_q  <= base_q + ilen_q;
                            state_q <= S_PSTART;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if ((state_q == S_IDLE) && start) begin
            stall_q <= '0;
        end else if (loading && cur_full && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_pe_feed_scheduler.sv
// tb/tb_pe_feed_scheduler.sv - self-checking bench for pe_feed_scheduler against a queue-based job model
module tb_pe_feed_scheduler;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int FW = 4;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [FW-1:0] filter_size;
    logic [AW-1:0] ifmap_len;
    logic [RW-1:0] num_rows;
    logic          busy;
    logic          done;
`ifdef STALL_CNT_EN
    logic [15:0]   stall_cycles;
`endif
    logic          pe_resp;
    logic          spur_pd;

    pe_feed_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    assign bus.pe_done = pe_resp | spur_pd;

    pe_feed_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FSIZE_WIDTH(FW), .ROWS_WIDTH(RW)) dut (
        .clk(clk), .rst(rst), .start(start), .filter_size(filter_size), .ifmap_len(ifmap_len),
        .num_rows(num_rows), .bus(bus), .busy(busy), .done(done)
`ifdef STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0]   exp_f[$];
    logic [DW+1:0]   exp_i[$];
    int filt_wr_cnt = 0, ifm_wr_cnt = 0, pe_start_cnt = 0, done_cnt = 0, ends_seen = 0;
    int ends_handled = 0, end_target = 0;
    int zero_done_cyc = -100, final_pd_cyc = -100;
    logic exp_done_now;

    function automatic logic [DW-1:0] fdat(input logic [AW-1:0] a);
        return {24'hF00000, a};
    endfunction

    function automatic logic [DW-1:0] idat(input logic [AW-1:0] a);
        return {24'hA50000, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Source SRAMs: contents encode their own address so every written word identifies its origin.
    always @(posedge clk) begin
        if (bus.filt_rd_en) bus.filt_rd_data <= fdat(bus.filt_rd_addr);
        if (bus.ifm_rd_en)  bus.ifm_rd_data  <= idat(bus.ifm_rd_addr);
    end

    task automatic build(input int f, input int l, input int r);
        exp_f.delete();
        exp_i.delete();
        if (f == 0 || l == 0 || r == 0) return;
        for (int ri = 0; ri < r; ri++) begin
            for (int i = 0; i < f; i++) exp_f.push_back(fdat(AW'(i)));
            for (int j = 0; j < l; j++)
                exp_i.push_back({(j == 0), (j == l - 1), idat(AW'((ri * l + j) % 256))});
        end
    endtask

    // PE model: completes each row a few cycles after its end-flagged word arrives.
    initial begin
        pe_resp = 1'b0;
        forever begin
            tick();
            if (ends_handled != ends_seen) begin
                ends_handled = ends_seen;
                repeat (3) tick();
                pe_resp = 1'b1;
                if (ends_handled == end_target) final_pd_cyc = cyc;
                tick();
                pe_resp = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("reset_outputs", 64'(|{bus.filt_rd_en, bus.filt_rd_addr, bus.ifm_rd_en, bus.ifm_rd_addr,
                    bus.filt_wr_en, bus.filt_wr_data, bus.ifm_wr_en, bus.ifm_wr_data, bus.pe_start, busy, done}), 64'(0));
`ifdef STALL_CNT_EN
                chk("reset_stall", 64'(stall_cycles), 64'(0));
`endif
            end else begin
                if (bus.filt_wr_en) begin
                    filt_wr_cnt++;
                    if (exp_f.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL filt_extra_write: got %0h, required no write", bus.filt_wr_data);
                    end else chk("filt_word", 64'(bus.filt_wr_data), 64'(exp_f.pop_front()));
                end
                if (bus.ifm_wr_en) begin
                    ifm_wr_cnt++;
                    if (bus.ifm_wr_data[DW]) ends_seen++;
                    if (exp_i.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL ifm_extra_write: got %0h, required no write", bus.ifm_wr_data);
                    end else chk("ifm_word", 64'(bus.ifm_wr_data), 64'(exp_i.pop_front()));
                end
                if (bus.filt_full) begin
                    chk("filt_rd_while_full", 64'(bus.filt_rd_en), 64'(0));
                    chk("filt_wr_while_full", 64'(bus.filt_wr_en), 64'(0));
                end
                if (bus.ifm_full) begin
                    chk("ifm_rd_while_full", 64'(bus.ifm_rd_en), 64'(0));
                    chk("ifm_wr_while_full", 64'(bus.ifm_wr_en), 64'(0));
                end
                if (bus.pe_start) pe_start_cnt++;
                exp_done_now = (cyc == zero_done_cyc) || (cyc == final_pd_cyc + 2);
                if (done || exp_done_now) chk("done_timing", 64'(done), 64'(exp_done_now));
                if (done) done_cnt++;
            end
        end
    end

    // sp: stall path (0 none, 1 filter, 2 ifmap), stalled for sl cycles after sa writes on that path.
    task automatic run_job(input int f, input int l, input int r, input int sp, input int sa,
                           input int sl, input bit spur);
        int fw0, iw0, ps0, dn0, t;
        bit zero, stalled;
        zero = (f == 0 || l == 0 || r == 0);
        fw0 = filt_wr_cnt; iw0 = ifm_wr_cnt; ps0 = pe_start_cnt; dn0 = done_cnt;
        end_target = ends_seen + (zero ? 0 : r);
        filter_size = FW'(f); ifmap_len = AW'(l); num_rows = RW'(r);
        start = 1'b1;
        if (zero) zero_done_cyc = cyc + 2;
        tick();
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'(1));
        if (spur) begin
            start = 1'b1; spur_pd = 1'b1;
            filter_size = 4'd7; ifmap_len = 8'd3; num_rows = 4'd1;
            tick();
            start = 1'b0; spur_pd = 1'b0;
        end
        t = 0; stalled = 1'b0;
        while (done_cnt == dn0 && t < 3000) begin
            if (sp != 0 && !stalled && ((sp == 1 ? filt_wr_cnt - fw0 : ifm_wr_cnt - iw0) >= sa)) begin
                if (sp == 1) bus.filt_full = 1'b1; else bus.ifm_full = 1'b1;
                repeat (sl) tick();
                bus.filt_full = 1'b0; bus.ifm_full = 1'b0;
                stalled = 1'b1;
            end
            tick();
            t++;
        end
        chk("done_pulses", 64'(done_cnt - dn0), 64'(1));
        tick(); tick();
        chk("pe_starts", 64'(pe_start_cnt - ps0), 64'(zero ? 0 : r));
        chk("filt_count", 64'(filt_wr_cnt - fw0), 64'(zero ? 0 : f * r));
        chk("ifm_count", 64'(ifm_wr_cnt - iw0), 64'(zero ? 0 : l * r));
        chk("filt_left", 64'(exp_f.size()), 64'(0));
        chk("ifm_left", 64'(exp_i.size()), 64'(0));
        chk("busy_idle", 64'(busy), 64'(0));
`ifdef STALL_CNT_EN
        chk("stall_cycles", 64'(stall_cycles), 64'(sp != 0 ? sl : 0));
`endif
    endtask

    initial begin
        int iw0, t;
        rst = 1'b0; start = 1'b0; filter_size = '0; ifmap_len = '0; num_rows = '0;
        bus.filt_full = 1'b0; bus.ifm_full = 1'b0; spur_pd = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();

        build(5, 12, 1);
        chk("model_first_word", 64'(exp_i[0]), 64'({2'b10, 32'hA500_0000}));
        chk("model_last_word", 64'(exp_i[11]), 64'({2'b01, 32'hA500_000B}));
        chk("model_filt4", 64'(exp_f[4]), 64'(32'hF000_0004));
        run_job(5, 12, 1, 0, 0, 0, 1'b0);

        build(5, 4, 3);
        chk("model_row2_first", 64'(exp_i[8]), 64'({2'b10, 32'hA500_0008}));
        chk("model_filt_total", 64'(exp_f.size()), 64'(15));
        run_job(5, 4, 3, 1, 2, 3, 1'b1);

        build(3, 10, 1);
        run_job(3, 10, 1, 2, 4, 6, 1'b0);

        build(3, 1, 2);
        chk("model_len1_flags", 64'(exp_i[1]), 64'({2'b11, 32'hA500_0001}));
        run_job(3, 1, 2, 0, 0, 0, 1'b0);

        build(0, 5, 1);
        run_job(0, 5, 1, 0, 0, 0, 1'b0);
        build(2, 0, 3);
        run_job(2, 0, 3, 0, 0, 0, 1'b0);

        build(4, 6, 2);
        iw0 = ifm_wr_cnt;
        filter_size = 4'd4; ifmap_len = 8'd6; num_rows = 4'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        t = 0;
        while (ifm_wr_cnt - iw0 < 3 && t < 500) begin tick(); t++; end
        chk("reset_wait", 64'(t < 500), 64'(1));
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        build(4, 6, 2);
        run_job(4, 6, 2, 0, 0, 0, 1'b0);

        build(1, 200, 2);
        chk("model_wrap_last", 64'(exp_i[399]), 64'({2'b01, 32'hA500_008F}));
        run_job(1, 200, 2, 0, 0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
